param_bram_fifo: RTL and testbench

//  Parametrised synchronous FIFO on inferred block RAM; successor to the fixed 8-bit x 8-deep

---
 rtl/param_bram_fifo.sv | 123 ++++++++++++
 tb/tb_param_bram_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_bram_fifo.sv
// param_bram_fifo: parametrised single-clock FIFO built on an inferred block RAM.
// Standard mode registers the head word on an accepted read. FWFT mode adds a
// presentation register in front of the RAM so the head word sits on buf_out
// without a read. The FWFT word count includes the presented word.
module param_bram_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter bit FWFT       = 1'b0,
   parameter int AF_THRESH  = (2**ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] buf_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] buf_out,
   output logic                  buf_empty,
   output logic                  buf_full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   fifo_counter
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   // Thresholds must leave a usable window between the two almost flags.
   generate
      if (AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
         $error("param_bram_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                  out_valid;      // FWFT only: buf_out holds a live word
   logic                  rd_acc, wr_acc, load;
   logic                  out_valid_nxt;
   logic [ADDR_WIDTH:0]   mem_cnt, cnt_nxt;

   // Accept decisions, RAM-to-output load and next count/presentation state.
   always_comb begin
      rd_acc        = rd_en && !buf_empty;
      wr_acc        = wr_en && (!buf_full || rd_acc);
      // Words still inside the RAM (the presented FWFT word has already left it).
      mem_cnt       = fifo_counter - {{ADDR_WIDTH{1'b0}}, out_valid};
      load          = rd_acc;
      out_valid_nxt = 1'b0;
      if (FWFT) begin
         // Refill the presentation register whenever it is free or being consumed.
         load          = (mem_cnt != '0) && (!out_valid || rd_acc);
         out_valid_nxt = load || (out_valid && !rd_acc);
      end
      cnt_nxt = fifo_counter;
      if (wr_acc && !rd_acc)
         cnt_nxt = fifo_counter + CNT_ONE;
      else if (rd_acc && !wr_acc)
         cnt_nxt = fifo_counter - CNT_ONE;
   end

   // Pointers, count, registered flags and sticky errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_counter <= '0;
         out_valid    <= 1'b0;
         buf_empty    <= 1'b1;
         buf_full     <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_counter <= '0;
         out_valid    <= 1'b0;
         buf_empty    <= 1'b1;
         buf_full     <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (load)   rd_ptr <= rd_ptr + PTR_ONE;
         fifo_counter <= cnt_nxt;
         out_valid    <= out_valid_nxt;
         buf_empty    <= FWFT ? !out_valid_nxt : (cnt_nxt == '0);
         buf_full     <= (cnt_nxt == DEPTH_C);
         almost_full  <= (cnt_nxt >= AF_C);
         almost_empty <= (cnt_nxt <= AE_C);
         overflow     <= overflow  | (wr_en && !wr_acc);
         underflow    <= underflow | (rd_en && buf_empty);
      end
   end

   // RAM write port; left without reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc && !flush)
         mem[wr_ptr] <= buf_in;
   end

   // RAM read port / output register; read-before-write covers full rd+wr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         buf_out <= '0;
      else if (flush)
         buf_out <= '0;
      else if (load)
         buf_out <= mem[rd_ptr];
   end

endmodule

// File: tb/tb_param_bram_fifo.sv
// Bench for param_bram_fifo: one standard and one FWFT instance share stimulus;
// a queue-based model is compared every cycle, plus literal spot checks.
module tb_param_bram_fifo;
   localparam int DW = 8, AW = 3, DEPTH = 8, AF = 6, AE = 2;

   logic          clk = 1'b0;
   logic          rst_n, flush, wr_en, rd_en;
   logic [DW-1:0] buf_in;

   logic [DW-1:0] o0_out, o1_out;
   logic          o0_empty, o0_full, o0_af, o0_ae, o0_ov, o0_un;
   logic          o1_empty, o1_full, o1_af, o1_ae, o1_ov, o1_un;
   logic [AW:0]   o0_cnt, o1_cnt;

   param_bram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0),
                     .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .buf_in(buf_in), .wr_en(wr_en),
      .rd_en(rd_en), .buf_out(o0_out), .buf_empty(o0_empty), .buf_full(o0_full),
      .almost_full(o0_af), .almost_empty(o0_ae), .overflow(o0_ov),
      .underflow(o0_un), .fifo_counter(o0_cnt));

   param_bram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1),
                     .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .buf_in(buf_in), .wr_en(wr_en),
      .rd_en(rd_en), .buf_out(o1_out), .buf_empty(o1_empty), .buf_full(o1_full),
      .almost_full(o1_af), .almost_empty(o1_ae), .overflow(o1_ov),
      .underflow(o1_un), .fifo_counter(o1_cnt));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] q0[$], q1[$];
   logic [DW-1:0] m_out0, m_out1;
   bit            m_vis1, m_ov0, m_un0, m_ov1, m_un1;
   bit            ra0, wa0, ra1, wa1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         q0.delete(); q1.delete();
         m_out0 = '0; m_out1 = '0; m_vis1 = 0;
         m_ov0 = 0; m_un0 = 0; m_ov1 = 0; m_un1 = 0;
      end else begin
         // standard: a read pops the head into the output register
         ra0 = rd_en && (q0.size() > 0);
         wa0 = wr_en && ((q0.size() < DEPTH) || ra0);
         if (rd_en && q0.size() == 0) m_un0 = 1;
         if (wr_en && !wa0)           m_ov0 = 1;
         if (ra0) m_out0 = q0.pop_front();
         if (wa0) q0.push_back(buf_in);
         // FWFT: head becomes visible one edge after it is stored
         ra1 = rd_en && m_vis1;
         wa1 = wr_en && ((q1.size() < DEPTH) || ra1);
         if (rd_en && !m_vis1) m_un1 = 1;
         if (wr_en && !wa1)    m_ov1 = 1;
         if (ra1) begin
            void'(q1.pop_front());
            m_vis1 = (q1.size() > 0);
         end else begin
            m_vis1 = m_vis1 || (q1.size() > 0);
         end
         if (wa1) q1.push_back(buf_in);
         if (m_vis1) m_out1 = q1[0];
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("std.count", 32'(o0_cnt), 32'(q0.size()));
      chk("std.empty", 32'(o0_empty), 32'(q0.size() == 0));
      chk("std.full",  32'(o0_full),  32'(q0.size() == DEPTH));
      chk("std.af",    32'(o0_af),    32'(q0.size() >= AF));
      chk("std.ae",    32'(o0_ae),    32'(q0.size() <= AE));
      chk("std.ovf",   32'(o0_ov),    32'(m_ov0));
      chk("std.unf",   32'(o0_un),    32'(m_un0));
      chk("std.data",  32'(o0_out),   32'(m_out0));
      chk("fwft.count", 32'(o1_cnt),  32'(q1.size()));
      chk("fwft.empty", 32'(o1_empty), 32'(!m_vis1));
      chk("fwft.full",  32'(o1_full),  32'(q1.size() == DEPTH));
      chk("fwft.af",    32'(o1_af),    32'(q1.size() >= AF));
      chk("fwft.ae",    32'(o1_ae),    32'(q1.size() <= AE));
      chk("fwft.ovf",   32'(o1_ov),    32'(m_ov1));
      chk("fwft.unf",   32'(o1_un),    32'(m_un1));
      chk("fwft.data",  32'(o1_out),   32'(m_out1));
   end

   // One clock: drive inputs now, return at the next falling edge.
   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      wr_en = w; buf_in = d; rd_en = r; flush = f;
      @(negedge clk);
      wr_en = 0; rd_en = 0; flush = 0;
   endtask

   logic [DW-1:0] pop_exp [8];
   int wp, rp;

   initial begin
      rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; buf_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1;

      // async reset mid-cycle
      for (int i = 0; i < 3; i++) cyc(1, 8'(i + 1), 0, 0);
      chk("pre_rst.count", 32'(o0_cnt), 3);
      #2 rst_n = 0;
      #1;
      chk("rst.count", 32'(o0_cnt), 0);
      chk("rst.empty", 32'(o0_empty), 1);
      chk("rst.ae",    32'(o0_ae), 1);
      chk("rst.full",  32'(o0_full), 0);
      chk("rst.data",  32'(o0_out), 0);
      chk("rst.fwft_count", 32'(o1_cnt), 0);
      chk("rst.fwft_empty", 32'(o1_empty), 1);
      @(negedge clk);
      rst_n = 1;

      // fill to full, overflow, full rd+wr, drain
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 8'(i * 10), 0, 0);
         if (i == 5) chk("fill.af_at5", 32'(o0_af), 0);
         if (i == 6) chk("fill.af_at6", 32'(o0_af), 1);
      end
      chk("fill.full",  32'(o0_full), 1);
      chk("fill.count", 32'(o0_cnt), 8);
      cyc(1, 8'd90, 0, 0);
      chk("ovf.flag",  32'(o0_ov), 1);
      chk("ovf.count", 32'(o0_cnt), 8);
      cyc(1, 8'd99, 1, 0);
      chk("fullrw.count", 32'(o0_cnt), 8);
      chk("fullrw.data",  32'(o0_out), 10);
      pop_exp = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd99};
      for (int i = 0; i < 8; i++) begin
         cyc(0, '0, 1, 0);
         chk("drain.data", 32'(o0_out), 32'(pop_exp[i]));
      end
      chk("drain.empty", 32'(o0_empty), 1);

      // pointer wrap
      cyc(0, '0, 0, 1);
      for (int i = 1; i <= 20; i++) begin
         cyc(1, 8'(i), 0, 0);
         cyc(0, '0, 1, 0);
         chk("wrap.data",   32'(o0_out), 32'(i));
         chk("wrap.cnt_le1", 32'(o0_cnt <= 1), 1);
      end

      // FWFT presentation timing
      cyc(0, '0, 0, 1);
      cyc(1, 8'hA5, 0, 0);
      chk("fwft.wr_edge_empty", 32'(o1_empty), 1);
      cyc(0, '0, 0, 0);
      chk("fwft.show_data",  32'(o1_out), 32'h A5);
      chk("fwft.show_empty", 32'(o1_empty), 0);
      cyc(1, 8'h5A, 0, 0);
      cyc(0, '0, 1, 0);
      chk("fwft.next_data",  32'(o1_out), 32'h5A);
      chk("fwft.next_empty", 32'(o1_empty), 0);
      cyc(0, '0, 1, 0);
      chk("fwft.last_empty", 32'(o1_empty), 1);
      chk("fwft.last_count", 32'(o1_cnt), 0);

      // flush clears contents and sticky errors
      cyc(0, '0, 0, 1);
      for (int i = 0; i < 9; i++) cyc(1, 8'(i + 1), 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
      chk("flush.pre_count", 32'(o0_cnt), 5);
      chk("flush.pre_ovf",   32'(o0_ov), 1);
      cyc(1, 8'h77, 1, 1);
      chk("flush.count", 32'(o0_cnt), 0);
      chk("flush.empty", 32'(o0_empty), 1);
      chk("flush.ovf",   32'(o0_ov), 0);
      chk("flush.data",  32'(o0_out), 0);
      cyc(0, '0, 1, 0);
      chk("unf.flag",  32'(o0_un), 1);
      chk("unf.data",  32'(o0_out), 0);
      chk("unf.count", 32'(o0_cnt), 0);
      chk("unf.fwft_flag", 32'(o1_un), 1);

      // randomized traffic with shifting bias, rare flushes and one async reset
      for (int k = 0; k < 3000; k++) begin
         wp = ((k / 500) % 3 == 0) ? 70 : ((k / 500) % 3 == 1) ? 30 : 50;
         rp = 100 - wp;
         cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 199) == 0);
         if (k == 1500) begin
            #2 rst_n = 0;
            #1 rst_n = 1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
